// File: rtl/game_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : game_pkg                                                   |
// | Brief   : shared game state and judge grade types                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2,
        OVER = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        PERFECT = 2'd1,
        GOOD    = 2'd2,
        MISS    = 2'd3
    } grade_t;

    localparam int MIN_PERIOD = 4;

endpackage
`default_nettype wire

// File: rtl/lane_judge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : lane_judge                                                 |
// | Brief   : one note lane: button sync/edge, note shifter, judge grade |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lane_judge
    import game_pkg::*;
#(
    parameter int SONG_LEN = 32,
    parameter int DISP_LEN = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic                i_active,
    input  logic                i_tick,
    input  logic                i_early,
    input  logic                i_clear_disp,
    input  logic [SONG_LEN-1:0] i_notes,
    input  logic                i_button,
    output logic [1:0]          o_grade,
    output logic [DISP_LEN-1:0] o_display,
    output logic                o_empty
);

    localparam int LW = SONG_LEN + DISP_LEN;

    logic [2:0]          r_sync;
    logic [LW-1:0]       r_lane;
    logic                r_consumed;
    logic [DISP_LEN-1:0] r_disp;
    logic                w_press;
    logic                w_live;
    logic [LW-1:0]       w_shifted;
    grade_t              w_grade;

    // [0],[1] form the synchroniser, [2] holds the previous synchronised level
    always_ff @(posedge clk) begin
        if (rst) r_sync <= '0;
        else     r_sync <= {r_sync[1], r_sync[0], i_button};
    end

    assign w_press   = r_sync[1] & ~r_sync[2];
    assign w_live    = r_lane[0] & ~r_consumed;
    assign w_shifted = r_lane >> 1;

    always_comb begin
        w_grade = NONE;
        if (i_active) begin
            if (w_press)
                w_grade = w_live ? (i_early ? PERFECT : GOOD) : MISS;
            else if (i_tick && w_live)
                w_grade = MISS;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane     <= '0;
            r_consumed <= 1'b0;
            r_disp     <= '0;
        end else if (i_load) begin
            r_lane     <= {{DISP_LEN{1'b0}}, i_notes};
            r_consumed <= 1'b0;
            r_disp     <= '0;
        end else if (i_clear_disp) begin
            r_disp     <= '0;
        end else if (i_active) begin
            if (i_tick) begin
                r_lane     <= w_shifted;
                r_consumed <= 1'b0;
                r_disp     <= w_shifted[DISP_LEN-1:0];
            end else if (w_press && w_live) begin
                r_consumed <= 1'b1;
            end
        end
    end

    assign o_grade   = w_grade;
    assign o_display = r_disp;
    assign o_empty   = (r_lane == '0);

endmodule
`default_nettype wire

// File: rtl/multi_lane_game.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : multi_lane_game                                            |
// | Brief   : multi-lane rhythm game core: timer, FSM, scoring           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module multi_lane_game
    import game_pkg::*;
#(
    parameter int NUM_LANES   = 4,
    parameter int SONG_LEN    = 32,
    parameter int DISP_LEN    = 8,
    parameter int SCORE_W     = 12,
    parameter int MAX_MISSES  = 16,
    parameter int COMBO_BONUS = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          pause,
    input  logic [22:0]                   period,
    input  logic [NUM_LANES*SONG_LEN-1:0] notes,
    input  logic [NUM_LANES-1:0]          buttons,
    output logic [NUM_LANES*DISP_LEN-1:0] display,
    output logic [SCORE_W-1:0]            score,
    output logic [SCORE_W-1:0]            num_hits,
    output logic [SCORE_W-1:0]            num_misses,
    output logic [SCORE_W-1:0]            combo,
    output logic [SCORE_W-1:0]            max_combo,
    output logic                          perfect_p,
    output logic                          hit_p,
    output logic                          miss_p,
    output logic [1:0]                    state
);

    localparam int CW = $clog2(NUM_LANES + 1);
    localparam int AW = SCORE_W + CW + 3;
    localparam logic [SCORE_W-1:0] c_max = '1;

    state_t             r_state, w_state_next;
    logic               r_start_d;
    logic [22:0]        r_per, r_tc;
    logic [SCORE_W-1:0] r_score, r_hits, r_misses, r_combo, r_max;
    logic               r_perfect_p, r_hit_p, r_miss_p;
    logic               w_load, w_active, w_tick, w_early;
    logic [1:0]         w_grade [NUM_LANES];
    logic [NUM_LANES-1:0] w_empty;
    logic [CW-1:0]      w_np, w_ng, w_nm, w_nh;
    logic [AW-1:0]      w_add;
    logic [SCORE_W-1:0] w_score_next, w_hits_next, w_misses_next, w_combo_next;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                    input logic [AW-1:0] b);
        logic [AW-1:0] s;
        s = AW'(a) + b;
        return (s > AW'(c_max)) ? c_max : s[SCORE_W-1:0];
    endfunction

    assign w_load   = (r_state != PLAY) && start && !r_start_d;
    assign w_active = (r_state == PLAY) && !pause;
    assign w_tick   = w_active && (r_tc == r_per - 23'd1);
    // A tick-cycle press sees tc == per-1, which is never early since per >= 4
    assign w_early  = r_tc < {1'b0, r_per[22:1]};

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        lane_judge #(
            .SONG_LEN (SONG_LEN),
            .DISP_LEN (DISP_LEN)
        ) u_lane (
            .clk          (clk),
            .rst          (rst),
            .i_load       (w_load),
            .i_active     (w_active),
            .i_tick       (w_tick),
            .i_early      (w_early),
            .i_clear_disp (r_state != PLAY),
            .i_notes      (notes[l*SONG_LEN +: SONG_LEN]),
            .i_button     (buttons[l]),
            .o_grade      (w_grade[l]),
            .o_display    (display[l*DISP_LEN +: DISP_LEN]),
            .o_empty      (w_empty[l])
        );
    end

    always_comb begin
        w_np = '0;
        w_ng = '0;
        w_nm = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (w_grade[l] == PERFECT) w_np = w_np + CW'(1);
            if (w_grade[l] == GOOD)    w_ng = w_ng + CW'(1);
            if (w_grade[l] == MISS)    w_nm = w_nm + CW'(1);
        end
    end

    assign w_nh  = w_np + w_ng;
    assign w_add = AW'({w_np, 1'b0}) + AW'(w_ng)
                 + ((r_combo >= SCORE_W'(COMBO_BONUS)) ? AW'(w_nh) : AW'(0));

    assign w_score_next  = sat_add(r_score, w_add);
    assign w_hits_next   = sat_add(r_hits, AW'(w_nh));
    assign w_misses_next = sat_add(r_misses, AW'(w_nm));
    assign w_combo_next  = (w_nm != '0) ? '0 : sat_add(r_combo, AW'(w_nh));

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            PLAY: begin
                if (w_misses_next >= SCORE_W'(MAX_MISSES))
                    w_state_next = OVER;
                else if ((&w_empty) && (w_nh == '0) && (w_nm == '0))
                    w_state_next = DONE;
            end
            default: begin
                if (w_load) w_state_next = PLAY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_start_d   <= 1'b0;
            r_per       <= 23'(MIN_PERIOD);
            r_tc        <= '0;
            r_score     <= '0;
            r_hits      <= '0;
            r_misses    <= '0;
            r_combo     <= '0;
            r_max       <= '0;
            r_perfect_p <= 1'b0;
            r_hit_p     <= 1'b0;
            r_miss_p    <= 1'b0;
        end else begin
            r_start_d   <= start;
            r_perfect_p <= 1'b0;
            r_hit_p     <= 1'b0;
            r_miss_p    <= 1'b0;
            if (w_load) begin
                r_per    <= (period < 23'(MIN_PERIOD)) ? 23'(MIN_PERIOD) : period;
                r_tc     <= '0;
                r_score  <= '0;
                r_hits   <= '0;
                r_misses <= '0;
                r_combo  <= '0;
                r_max    <= '0;
            end else if (w_active) begin
                r_tc        <= w_tick ? '0 : r_tc + 23'd1;
                r_score     <= w_score_next;
                r_hits      <= w_hits_next;
                r_misses    <= w_misses_next;
                r_combo     <= w_combo_next;
                r_max       <= (w_combo_next > r_max) ? w_combo_next : r_max;
                r_perfect_p <= (w_np != '0);
                r_hit_p     <= (w_nh != '0);
                r_miss_p    <= (w_nm != '0);
            end
        end
    end

    assign score      = r_score;
    assign num_hits   = r_hits;
    assign num_misses = r_misses;
    assign combo      = r_combo;
    assign max_combo  = r_max;
    assign perfect_p  = r_perfect_p;
    assign hit_p      = r_hit_p;
    assign miss_p     = r_miss_p;
    assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multi_lane_game.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_multi_lane_game                                         |
// | Brief   : random games against a song-position reference model      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_multi_lane_game;

    localparam int NL    = 4;
    localparam int SL    = 32;
    localparam int DL    = 8;
    localparam int SW    = 12;
    localparam int MAXM  = 10;
    localparam int BONUS = 8;
    localparam int SATV  = (1 << SW) - 1;

    logic              clk = 1'b0;
    logic              rst, start, pause;
    logic [22:0]       period;
    logic [NL*SL-1:0]  notes;
    logic [NL-1:0]     buttons;
    logic [NL*DL-1:0]  display;
    logic [SW-1:0]     score, num_hits, num_misses, combo, max_combo;
    logic              perfect_p, hit_p, miss_p;
    logic [1:0]        state;

    always #5 clk = ~clk;

    multi_lane_game #(
        .NUM_LANES(NL), .SONG_LEN(SL), .DISP_LEN(DL), .SCORE_W(SW),
        .MAX_MISSES(MAXM), .COMBO_BONUS(BONUS)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .period(period),
        .notes(notes), .buttons(buttons), .display(display), .score(score),
        .num_hits(num_hits), .num_misses(num_misses), .combo(combo),
        .max_combo(max_combo), .perfect_p(perfect_p), .hit_p(hit_p),
        .miss_p(miss_p), .state(state)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Model: state 0..3 = IDLE/PLAY/DONE/OVER; song progress is a tick count
    int              m_state, m_tc, m_per, m_pos;
    int              m_score, m_hits, m_miss, m_combo, m_max;
    bit              m_pp, m_hp, m_mp, m_start_prev;
    bit [NL-1:0]     m_cons, bh1, bh2, bh3;
    logic [NL*DL-1:0] m_disp;
    logic [NL*SL-1:0] song;

    function automatic bit note_at(input int l, input int k);
        if (k >= SL) return 1'b0;
        return song[l*SL + k];
    endfunction

    function automatic int sat(input int v);
        return (v > SATV) ? SATV : v;
    endfunction

    task automatic model_reset();
        m_state = 0; m_tc = 0; m_per = 4; m_pos = 0;
        m_score = 0; m_hits = 0; m_miss = 0; m_combo = 0; m_max = 0;
        m_pp = 0; m_hp = 0; m_mp = 0; m_start_prev = 0;
        m_cons = '0; bh1 = '0; bh2 = '0; bh3 = '0; m_disp = '0;
    endtask

    task automatic model_step();
        int  np, ng, nm, h, pos0;
        bit  tick, live, press, remaining;
        np = 0; ng = 0; nm = 0;
        if (rst) begin
            model_reset();
            return;
        end
        m_pp = 0; m_hp = 0; m_mp = 0;
        if (m_state != 1) begin
            m_disp = '0;
            if (start && !m_start_prev) begin
                song = notes; m_state = 1; m_tc = 0; m_pos = 0; m_cons = '0;
                m_per = (period < 4) ? 4 : int'(period);
                m_score = 0; m_hits = 0; m_miss = 0; m_combo = 0; m_max = 0;
            end
        end else begin
            pos0 = m_pos;
            if (!pause) begin
                tick = (m_tc == m_per - 1);
                for (int l = 0; l < NL; l++) begin
                    live  = note_at(l, m_pos) && !m_cons[l];
                    press = bh2[l] && !bh3[l];
                    if (press) begin
                        if (live) begin
                            if (m_tc < m_per / 2) np++; else ng++;
                            m_cons[l] = 1'b1;
                        end else nm++;
                    end else if (tick && live) nm++;
                end
                h = np + ng;
                m_score = sat(m_score + 2*np + ng + ((m_combo >= BONUS) ? h : 0));
                m_hits  = sat(m_hits + h);
                m_miss  = sat(m_miss + nm);
                m_combo = (nm > 0) ? 0 : sat(m_combo + h);
                if (m_combo > m_max) m_max = m_combo;
                m_pp = (np > 0); m_hp = (h > 0); m_mp = (nm > 0);
                if (tick) begin
                    m_cons = '0; m_pos++; m_tc = 0;
                    for (int l = 0; l < NL; l++)
                        for (int j = 0; j < DL; j++)
                            m_disp[l*DL + j] = note_at(l, m_pos + j);
                end else m_tc++;
            end
            remaining = 1'b0;
            for (int l = 0; l < NL; l++)
                for (int k = pos0; k < SL; k++)
                    if (note_at(l, k)) remaining = 1'b1;
            if (m_miss >= MAXM) m_state = 3;
            else if (!remaining && np + ng + nm == 0) m_state = 2;
        end
        m_start_prev = start;
        bh3 = bh2; bh2 = bh1; bh1 = buttons;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("state", 64'(state), 64'(m_state));
        check("score", 64'(score), 64'(m_score));
        check("num_hits", 64'(num_hits), 64'(m_hits));
        check("num_misses", 64'(num_misses), 64'(m_miss));
        check("combo", 64'(combo), 64'(m_combo));
        check("max_combo", 64'(max_combo), 64'(m_max));
        check("pulses", 64'({perfect_p, hit_p, miss_p}), 64'({m_pp, m_hp, m_mp}));
        check("display", 64'(display), 64'(m_disp));
    endtask

    // mode 0: press every note on time, 1: never press, 2: noisy play with pause/start
    task automatic play_game(input int mode, input int per_in, input bit do_rst);
        int cyc;
        bit want;
        for (int i = 0; i < NL*SL; i++) notes[i] = ($urandom_range(0, 3) == 0);
        period = 23'(per_in);
        start = 1'b1;
        cycle();
        start = 1'b0;
        cyc = 0;
        while (m_state == 1 && cyc < 8000) begin
            for (int l = 0; l < NL; l++) begin
                want = note_at(l, m_pos) && !m_cons[l] && (m_tc < 2);
                case (mode)
                    0:       buttons[l] = want;
                    1:       buttons[l] = 1'b0;
                    default: buttons[l] = ($urandom_range(0, 23) == 0) ? ~buttons[l]
                                          : (want && ($urandom_range(0, 3) != 0));
                endcase
            end
            if (mode == 2) begin
                if ($urandom_range(0, 40) == 0) pause = ~pause;
                start = ($urandom_range(0, 60) == 0);
            end
            cycle();
            cyc++;
            if (do_rst && cyc == 60) begin
                rst = 1'b1;
                cycle();
                rst = 1'b0;
                break;
            end
        end
        pause = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            buttons = 4'($urandom);
            cycle();
        end
        buttons = '0;
        cycle();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pause = 1'b0; period = 23'd8;
        notes = '0; buttons = '0;
        model_reset();
        song = '0;
        repeat (3) cycle();
        rst = 1'b0;
        cycle();
        play_game(0, 2, 1'b0);
        play_game(0, 10, 1'b0);
        play_game(1, 5, 1'b0);
        play_game(2, $urandom_range(0, 14), 1'b1);
        for (int g = 0; g < 4; g++)
            play_game(2, $urandom_range(0, 14), 1'b0);
        play_game(0, 12, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
